// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the data memory controller.
package data_mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    LEN_NONE = 2'b00,
    LEN_BYTE = 2'b01,
    LEN_HALF = 2'b10,
    LEN_WORD = 2'b11
  } len_e;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  length;
    logic        read_signed;
    logic [31:0] address;
    logic [31:0] write_data;
  } req_t;

  // Lanes touched by an access of the given length at byte offset offs.
  function automatic logic [NUM_LANES-1:0] byte_mask(input logic [1:0] length,
                                                     input logic [1:0] offs);
    case (length)
      LEN_BYTE: byte_mask = 4'b0001 << offs;
      LEN_HALF: byte_mask = 4'b0011 << {offs[1], 1'b0};
      LEN_WORD: byte_mask = 4'b1111;
      default:  byte_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface data_memory_ctrl_if;
  logic        MEM_req;
  logic        MEM_we;
  logic [1:0]  MEM_length;
  logic        MEM_read_signed;
  logic [31:0] MEM_address;
  logic [31:0] MEM_write_data;
  logic        MEM_ready;
  logic        MEM_resp_valid;
  logic [31:0] MEM_read_data;
  logic        MEM_fault;
  logic        MEM_init_done;

  modport master (
    output MEM_req, MEM_we, MEM_length, MEM_read_signed, MEM_address, MEM_write_data,
    input  MEM_ready, MEM_resp_valid, MEM_read_data, MEM_fault, MEM_init_done
  );

  modport slave (
    input  MEM_req, MEM_we, MEM_length, MEM_read_signed, MEM_address, MEM_write_data,
    output MEM_ready, MEM_resp_valid, MEM_read_data, MEM_fault, MEM_init_done
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]                        length,
  input  logic [1:0]                        offs,
  input  logic                              read_signed,
  input  logic [31:0]                       write_data,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  rword,
  output logic [NUM_LANES-1:0]              be,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  wlanes,
  output logic [31:0]                       load_data
);

  logic [31:0] shifted;

  assign be = byte_mask(length, offs);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_comb begin
      case (length)
        LEN_BYTE: wlanes[i] = write_data[7:0];
        LEN_HALF: wlanes[i] = write_data[LANE_W*(i%2) +: LANE_W];
        default:  wlanes[i] = write_data[LANE_W*i +: LANE_W];
      endcase
    end
  end

  assign shifted = rword >> {offs, 3'b000};

  always_comb begin
    case (length)
      LEN_BYTE: load_data = {{24{read_signed & shifted[7]}},  shifted[7:0]};
      LEN_HALF: load_data = {{16{read_signed & shifted[15]}}, shifted[15:0]};
      default:  load_data = rword;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte-lane writes, post-reset clear,
// configurable access latency and alignment/range fault reporting.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               SYS_clk,
  input  logic               SYS_reset,
  data_memory_ctrl_if.slave  mem
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e                           state, state_nxt;
  logic [AW-1:0]                    clr_cnt;
  logic [3:0]                       wait_cnt;
  req_t                             req_in, req_q, req_x;
  logic                             exec, fault, fault_q, init_done;
  logic [31:0]                      rdata;
  logic [AW-1:0]                    widx;
  logic [NUM_LANES-1:0]             be;
  logic [NUM_LANES-1:0][LANE_W-1:0] wlanes;
  logic [31:0]                      ld_data;
  logic [NUM_LANES-1:0][LANE_W-1:0] mem_q [DEPTH_WORDS];

  assign req_in = '{we:          mem.MEM_we,
                    length:      mem.MEM_length,
                    read_signed: mem.MEM_read_signed,
                    address:     mem.MEM_address,
                    write_data:  mem.MEM_write_data};

  // With no wait states the access executes on the accept edge from the live bus.
  assign req_x = (state == WAIT) ? req_q : req_in;
  assign widx  = req_x.address[AW+1:2];

  assign fault = (req_x.length == LEN_NONE)
               | ((req_x.length == LEN_HALF) & req_x.address[0])
               | ((req_x.length == LEN_WORD) & (req_x.address[1:0] != 2'b00))
               | (|req_x.address[31:AW+2]);

  mem_lane_align u_align (
    .length      (req_x.length),
    .offs        (req_x.address[1:0]),
    .read_signed (req_x.read_signed),
    .write_data  (req_x.write_data),
    .rword       (mem_q[widx]),
    .be          (be),
    .wlanes      (wlanes),
    .load_data   (ld_data)
  );

  always_comb begin
    state_nxt = state;
    exec      = 1'b0;
    case (state)
      INIT: if (clr_cnt == AW'(DEPTH_WORDS-1)) state_nxt = IDLE;
      IDLE: if (mem.MEM_req) begin
        if (WAIT_CYCLES > 0) state_nxt = WAIT;
        else begin
          state_nxt = RESP;
          exec      = 1'b1;
        end
      end
      WAIT: if (wait_cnt == 4'd0) begin
        state_nxt = RESP;
        exec      = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      state     <= INIT;
      clr_cnt   <= '0;
      wait_cnt  <= '0;
      req_q     <= '0;
      rdata     <= '0;
      fault_q   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
      if (state == INIT && state_nxt == IDLE) init_done <= 1'b1;
      if (state == IDLE && mem.MEM_req) begin
        req_q    <= req_in;
        wait_cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (exec) begin
        fault_q <= fault;
        rdata   <= (fault || req_x.we) ? 32'h0 : ld_data;
      end
    end
  end

  // Storage has no reset of its own; the INIT sweep clears it.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      if (state == INIT) begin
        mem_q[clr_cnt] <= '0;
      end else if (exec && !fault && req_x.we) begin
        for (int i = 0; i < NUM_LANES; i++)
          if (be[i]) mem_q[widx][i] <= wlanes[i];
      end
    end
  end

  assign mem.MEM_ready      = (state == IDLE);
  assign mem.MEM_resp_valid = (state == RESP);
  assign mem.MEM_read_data  = rdata;
  assign mem.MEM_fault      = fault_q;
  assign mem.MEM_init_done  = init_done;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench: vector table plus scoreboard, with timing/reset sequences.
module tb_data_memory_ctrl;
  import data_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int W     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_ctrl_if bus();

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst_n),
    .mem       (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        flt;
    string       name;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        flt;
    string       name;
  } vec_t;

  exp_t sb[$];
  int   resp_cyc[$];
  vec_t vt[$];
  int   tests = 0;
  int   fails = 0;
  int   resp_cnt = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Scoreboard: pop one expectation per response strobe.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.MEM_resp_valid === 1'b1) begin
      resp_cnt++;
      resp_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 want no response");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_data"},  bus.MEM_read_data, e.data);
        chk({e.name, "_fault"}, {31'b0, bus.MEM_fault}, {31'b0, e.flt});
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] len, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.MEM_req = 1'b1; bus.MEM_we = we; bus.MEM_length = len;
    bus.MEM_read_signed = sgn; bus.MEM_address = addr; bus.MEM_write_data = wd;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.MEM_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got ready=0 want 1 within 200 cycles");
    end
  endtask

  task automatic issue(input vec_t v);
    wait_ready();
    drive(v.we, v.len, v.sgn, v.addr, v.wd);
    sb.push_back('{v.exp, v.flt, v.name});
    @(posedge clk); #1;
    bus.MEM_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_init(input string n);
    int c = 0;
    while (bus.MEM_init_done !== 1'b1 && c < 1000) begin @(posedge clk); #1; c++; end
    chk(n, c, DEPTH);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin : main
    logic [4:0] rdy_e, rv_e;
    int rc;
    drive(0, LEN_NONE, 0, 0, 0);
    bus.MEM_req = 1'b0;

    // Vector table
    vt.push_back('{1, LEN_WORD, 0, 32'h010, 32'hDEADBEEF, 32'h0,        0, "st_w_10"});
    vt.push_back('{0, LEN_BYTE, 1, 32'h013, 32'h0,        32'hFFFFFFDE, 0, "ld_bs_13"});
    vt.push_back('{0, LEN_BYTE, 0, 32'h010, 32'h0,        32'h000000EF, 0, "ld_bu_10"});
    vt.push_back('{0, LEN_HALF, 0, 32'h012, 32'h0,        32'h0000DEAD, 0, "ld_hu_12"});
    vt.push_back('{0, LEN_HALF, 1, 32'h010, 32'h0,        32'hFFFFBEEF, 0, "ld_hs_10"});
    vt.push_back('{1, LEN_HALF, 0, 32'h011, 32'h1234,     32'h0,        1, "st_h_11_mis"});
    vt.push_back('{0, LEN_WORD, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0, "ld_w_10_a"});
    vt.push_back('{1, LEN_WORD, 0, 32'h012, 32'h1,        32'h0,        1, "st_w_12_mis"});
    vt.push_back('{0, LEN_NONE, 0, 32'h010, 32'h0,        32'h0,        1, "ld_len00"});
    vt.push_back('{0, LEN_WORD, 0, 32'h400, 32'h0,        32'h0,        1, "ld_w_400_oor"});
    vt.push_back('{0, LEN_WORD, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0, "ld_w_10_b"});
    vt.push_back('{1, LEN_HALF, 0, 32'h012, 32'hABCD1234, 32'h0,        0, "st_h_12"});
    vt.push_back('{1, LEN_BYTE, 0, 32'h011, 32'h99887755, 32'h0,        0, "st_b_11"});
    vt.push_back('{0, LEN_WORD, 1, 32'h010, 32'h0,        32'h123455EF, 0, "ld_w_10_c"});
    vt.push_back('{0, LEN_BYTE, 1, 32'h011, 32'h0,        32'h00000055, 0, "ld_bs_11"});
    vt.push_back('{0, LEN_HALF, 1, 32'h012, 32'h0,        32'h00001234, 0, "ld_hs_12"});
    vt.push_back('{1, LEN_WORD, 0, 32'h3FC, 32'h80000001, 32'h0,        0, "st_w_3fc"});
    vt.push_back('{0, LEN_BYTE, 1, 32'h3FF, 32'h0,        32'hFFFFFF80, 0, "ld_bs_3ff"});
    vt.push_back('{0, LEN_HALF, 0, 32'h3FE, 32'h0,        32'h00008000, 0, "ld_hu_3fe"});
    vt.push_back('{0, LEN_BYTE, 0, 32'h3FC, 32'h0,        32'h00000001, 0, "ld_bu_3fc"});
    vt.push_back('{0, LEN_WORD, 0, 32'h3FD, 32'h0,        32'h0,        1, "ld_w_3fd_mis"});

    // Reset state and clear sequence length
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",     {31'b0, bus.MEM_ready},      32'h0);
    chk("rst_resp",      {31'b0, bus.MEM_resp_valid}, 32'h0);
    chk("rst_rdata",     bus.MEM_read_data,           32'h0);
    chk("rst_fault",     {31'b0, bus.MEM_fault},      32'h0);
    chk("rst_init_done", {31'b0, bus.MEM_init_done},  32'h0);
    rst_n = 1'b1;
    wait_init("init_cycles");
    issue('{0, LEN_WORD, 0, 32'h3FC, 32'h0, 32'h0, 0, "ld_w_3fc_init"});
    drain();

    foreach (vt[i]) issue(vt[i]);
    drain();

    // Latency/ready profile with a request held through WAIT; bus changes are ignored
    wait_ready();
    drive(0, LEN_WORD, 0, 32'h010, 32'h0);
    sb.push_back('{32'h123455EF, 1'b0, "t4_first"});
    @(posedge clk); #1;
    drive(0, LEN_HALF, 0, 32'h012, 32'h0);
    sb.push_back('{32'h00001234, 1'b0, "t4_second"});
    rdy_e = 5'b10000;
    rv_e  = 5'b01000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t4_ready_c%0d", c), {31'b0, bus.MEM_ready},      {31'b0, rdy_e[c]});
      chk($sformatf("t4_rv_c%0d", c),    {31'b0, bus.MEM_resp_valid}, {31'b0, rv_e[c]});
    end
    @(posedge clk); #1;
    bus.MEM_req = 1'b0;
    @(negedge clk);
    chk("t4_second_accepted", {31'b0, bus.MEM_ready}, 32'h0);
    drain();

    // Reset during WAIT of a store: no response, memory re-cleared
    wait_ready();
    drive(1, LEN_WORD, 0, 32'h020, 32'hCAFEF00D);
    @(posedge clk); #1;
    bus.MEM_req = 1'b0;
    rc = resp_cnt;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_ready",     {31'b0, bus.MEM_ready},     32'h0);
    chk("t5_init_done", {31'b0, bus.MEM_init_done}, 32'h0);
    chk("t5_rdata",     bus.MEM_read_data,          32'h0);
    rst_n = 1'b1;
    wait_init("t5_reinit_cycles");
    chk("t5_no_resp", resp_cnt, rc);
    issue('{0, LEN_WORD, 0, 32'h020, 32'h0, 32'h0, 0, "t5_ld_20"});
    issue('{0, LEN_WORD, 0, 32'h010, 32'h0, 32'h0, 0, "t5_ld_10_cleared"});
    drain();

    // Back-to-back store then load, checking response spacing
    resp_cyc.delete();
    issue('{1, LEN_BYTE, 0, 32'h007, 32'h000000AA, 32'h0,        0, "t6_st_b_7"});
    issue('{0, LEN_WORD, 0, 32'h004, 32'h0,        32'hAA000000, 0, "t6_ld_w_4"});
    drain();
    if (resp_cyc.size() == 2) chk("t6_spacing", resp_cyc[1] - resp_cyc[0], W + 2);
    else chk("t6_resp_count", resp_cyc.size(), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
